// File: rtl/usb_rx_pkt_unpacker.sv
// usb_rx_pkt_unpacker: drains the USB RX data FIFO for one packet at a time.
// DATA0/DATA1 packets have their trailing 2 CRC bytes held back in a 2-entry
// skid buffer, CRC16 is checked over every popped byte, and the payload is
// streamed out on a valid/ready port. One pkt_done pulse per packet carries
// the status (pkt_ok, pkt_len, pkt_pid).
// Optional: define USB_RX_DROP_CNT_EN to add the saturating drop_cnt output.
module usb_rx_pkt_unpacker #(
  parameter int unsigned MAX_PAYLOAD = 64,
  parameter int unsigned LEN_W       = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       r_data,
  input  logic             empty,
  output logic             r_enable,
  input  logic             rcving,
  input  logic             r_error,
  input  logic [3:0]       PID,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             pkt_done,
  output logic             pkt_ok,
  output logic [LEN_W-1:0] pkt_len,
  output logic [3:0]       pkt_pid
`ifdef USB_RX_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  localparam logic [3:0]       PidData0   = 4'b0011;
  localparam logic [3:0]       PidData1   = 4'b1011;
  localparam logic [15:0]      CrcInit    = 16'hFFFF;
  localparam logic [15:0]      CrcResidue = 16'h800D;
  localparam logic [LEN_W-1:0] MaxLen     = LEN_W'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    StIdle,
    StActive,
    StFlush,
    StEval,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       skid0_q, skid0_d;     // oldest buffered byte
  logic [7:0]       skid1_q, skid1_d;     // newest buffered byte
  logic [1:0]       skid_cnt_q, skid_cnt_d;
  logic [15:0]      crc_q, crc_d;
  logic [LEN_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             pkt_ok_q, pkt_ok_d;
  logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
  logic [3:0]       pkt_pid_q, pkt_pid_d;

  logic can_accept;
  logic is_data;
  logic act_pop;
  logic fwd_load;

  // Serial CRC16 over one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] b);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      fb = b[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return c;
  endfunction

  assign is_data = (pkt_pid_q == PidData0) || (pkt_pid_q == PidData1);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (rcving) state_d = StActive;
      StActive: begin
        if (r_error) begin
          state_d = StFlush;
        end else if (!rcving && empty && !r_enable) begin
          state_d = StEval;
        end
      end
      StFlush:  if (!rcving && empty) state_d = StDone;
      StEval:   state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs: FIFO pop strobe and end-of-packet pulse.
  always_comb begin
    can_accept = 1'b1;
    if (state_q == StActive) begin
      // With a full skid buffer a pop must push the oldest byte to the output register.
      can_accept = (skid_cnt_q < 2'd2) | ~out_valid_q | out_ready;
    end
    r_enable = ((state_q == StActive) || (state_q == StFlush)) && !empty && can_accept;
    pkt_done = (state_q == StDone);
  end

  // Datapath next-state: skid buffer, CRC, output register and packet status.
  always_comb begin
    skid0_d     = skid0_q;
    skid1_d     = skid1_q;
    skid_cnt_d  = skid_cnt_q;
    crc_d       = crc_q;
    fwd_cnt_d   = fwd_cnt_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    pkt_ok_d    = pkt_ok_q;
    pkt_len_d   = pkt_len_q;
    pkt_pid_d   = pkt_pid_q;
    fwd_load    = 1'b0;
    act_pop     = r_enable && (state_q == StActive);

    if (state_q == StIdle && rcving) begin
      pkt_pid_d  = PID;
      fwd_cnt_d  = '0;
      crc_d      = CrcInit;
      ovf_d      = 1'b0;
      skid_cnt_d = 2'd0;
    end

    if (act_pop) begin
      crc_d = crc16_byte(crc_q, r_data);
      if (is_data) begin
        unique case (skid_cnt_q)
          2'd0: begin
            skid0_d    = r_data;
            skid_cnt_d = 2'd1;
          end
          2'd1: begin
            skid1_d    = r_data;
            skid_cnt_d = 2'd2;
          end
          default: begin
            skid0_d = skid1_q;
            skid1_d = r_data;
            if (fwd_cnt_q == MaxLen) begin
              ovf_d = 1'b1;  // byte is dropped, count saturates
            end else begin
              fwd_load  = 1'b1;
              fwd_cnt_d = fwd_cnt_q + LEN_W'(1);
            end
          end
        endcase
      end
    end

    // A pending output byte survives DONE/IDLE until the consumer takes it.
    if (fwd_load) begin
      out_valid_d = 1'b1;
      out_data_d  = skid0_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (state_q == StEval) begin
      pkt_ok_d  = is_data ? ((crc_q == CrcResidue) && (skid_cnt_q == 2'd2) && !ovf_q) : 1'b1;
      pkt_len_d = is_data ? fwd_cnt_q : '0;
    end else if (state_q == StFlush && !rcving && empty) begin
      pkt_ok_d  = 1'b0;
      pkt_len_d = fwd_cnt_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid0_q     <= '0;
      skid1_q     <= '0;
      skid_cnt_q  <= 2'd0;
      crc_q       <= CrcInit;
      fwd_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_len_q   <= '0;
      pkt_pid_q   <= '0;
    end else begin
      skid0_q     <= skid0_d;
      skid1_q     <= skid1_d;
      skid_cnt_q  <= skid_cnt_d;
      crc_q       <= crc_d;
      fwd_cnt_q   <= fwd_cnt_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_len_q   <= pkt_len_d;
      pkt_pid_q   <= pkt_pid_d;
    end
  end

`ifdef USB_RX_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Count failed packets, saturating.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (state_q == StDone && !pkt_ok_q && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign pkt_ok    = pkt_ok_q;
  assign pkt_len   = pkt_len_q;
  assign pkt_pid   = pkt_pid_q;

endmodule
